// File: rtl/spectrum_frame_sequencer.sv
// Turns decimated FFT frames into per-bin bar levels through one shared log2 unit.
// Levels are committed only in blanking. Define SPECTRUM_PEAK_HOLD_EN for decaying peak hold.
module spectrum_frame_sequencer #(
  parameter int NBINS        = 32,
  parameter int DW           = 16,
  parameter int LW           = 5,
  parameter int FRAME_DIV    = 8,
  parameter int DECAY_FRAMES = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NBINS*DW-1:0] i_fft_data,
  input  logic                i_fft_done,
  input  logic                i_blank,
  output logic [DW-1:0]       o_log2_in,
  input  logic [DW-1:0]       i_log2_out,
  output logic [NBINS*LW-1:0] o_level,
  output logic                o_frame_valid,
  output logic                o_busy,
  output logic                o_overrun
);

  localparam int DIVW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int KW   = $clog2(NBINS);
  localparam logic [DW-1:0] MAG_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, WAIT, COMMIT} state_t;
  state_t state, next_state;

  logic [DIVW-1:0]       div_cnt;
  logic                  pending;
  logic [KW-1:0]         bin_idx;
  logic [NBINS*DW-1:0]   snapshot;
  logic [NBINS*DW-1:0]   work;
  logic [NBINS*LW-1:0]   shadow;
  logic                  accept;
  logic                  start_calc;
  logic                  last_bin;
  logic                  commit;
  logic [DW-1:0]         cur_sample;
  logic [DW-1:0]         cur_mag;
  logic [LW-1:0]         cur_level;

  assign accept     = i_fft_done && (div_cnt == '0);
  assign start_calc = (state == IDLE) && pending && i_blank;
  assign last_bin   = (bin_idx == KW'(NBINS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pending && i_blank) next_state = CALC;
      CALC:    if (last_bin) next_state = WAIT;
      WAIT:    if (i_blank) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != IDLE);
    o_log2_in = '0;
    commit    = 1'b0;
    case (state)
      CALC:    o_log2_in = cur_mag;
      COMMIT:  commit = 1'b1;
      default: ;
    endcase
  end

  // The most negative sample has no positive twin, so it saturates.
  always_comb begin
    cur_sample = work[int'(bin_idx)*DW +: DW];
    if (!cur_sample[DW-1])        cur_mag = cur_sample;
    else if (cur_sample == NEG_MIN) cur_mag = MAG_MAX;
    else                          cur_mag = -cur_sample;
  end

  always_comb begin
    if (cur_mag == '0)                cur_level = '0;
    else if (i_log2_out > DW'(15))    cur_level = LW'(16);
    else                              cur_level = LW'(i_log2_out) + LW'(1);
  end

  // CALC works on a private copy so a frame accepted on the start edge stays pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt   <= '0;
      pending   <= 1'b0;
      snapshot  <= '0;
      work      <= '0;
      shadow    <= '0;
      bin_idx   <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (i_fft_done)
        div_cnt <= (div_cnt == DIVW'(FRAME_DIV - 1)) ? '0 : div_cnt + 1'b1;
      o_overrun <= accept && (state == CALC);
      if (accept && (state != CALC)) begin
        snapshot <= i_fft_data;
        pending  <= 1'b1;
      end else if (start_calc) begin
        pending  <= 1'b0;
      end
      if (start_calc) begin
        work    <= snapshot;
        bin_idx <= '0;
      end else if (state == CALC) begin
        shadow[int'(bin_idx)*LW +: LW] <= cur_level;
        bin_idx <= last_bin ? '0 : bin_idx + 1'b1;
      end
    end
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam int DCW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [DCW-1:0]        decay_cnt;
  logic                  decay_now;
  logic [LW-1:0]         held_dec [NBINS];
  logic [NBINS*LW-1:0]   peak_level;

  assign decay_now = (decay_cnt == DCW'(DECAY_FRAMES - 1));

  // The committed level doubles as the held peak; it decays before the max is taken.
  always_comb begin
    peak_level = '0;
    for (int k = 0; k < NBINS; k++) begin
      held_dec[k] = o_level[k*LW +: LW];
      if (decay_now && (held_dec[k] != '0)) held_dec[k] = held_dec[k] - 1'b1;
      peak_level[k*LW +: LW] = (shadow[k*LW +: LW] > held_dec[k]) ? shadow[k*LW +: LW] : held_dec[k];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_level       <= '0;
      o_frame_valid <= 1'b0;
      decay_cnt     <= '0;
    end else begin
      o_frame_valid <= commit;
      if (commit) begin
        o_level   <= peak_level;
        decay_cnt <= decay_now ? '0 : decay_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_level       <= '0;
      o_frame_valid <= 1'b0;
    end else begin
      o_frame_valid <= commit;
      if (commit) o_level <= shadow;
    end
  end
`endif

endmodule
